// File: rtl/sweep_peak_hold.sv
// Sweep sequencer with peak-hold: steps the servo through 0..POS_MAX and keeps
// the largest ADC sample and the position where it occurred, then parks there.
module sweep_peak_hold #(
    parameter int DATA_W        = 12,
    parameter int POS_W         = 8,
    parameter int POS_MAX       = 180,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              gt,
    output logic [DATA_W-1:0] lv,
    output logic [POS_W-1:0]  pos,
    output logic [POS_W-1:0]  peak_pos,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]    RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [POS_W-1:0] LAST   = POS_W'(POS_MAX);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [DATA_W-1:0] lv_nx;
    logic [POS_W-1:0]  pos_nx, peak_pos_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            lv       <= '0;
            pos      <= '0;
            peak_pos <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            lv       <= lv_nx;
            pos      <= pos_nx;
            peak_pos <= peak_pos_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        lv_nx       = lv;
        pos_nx      = pos;
        peak_pos_nx = peak_pos;
        case (state)
            IDLE: begin
                if (start) begin
                    lv_nx       = '0;
                    peak_pos_nx = '0;
                    pos_nx      = '0;
                    cnt_nx      = RELOAD;
                    state_nx    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) state_nx = SAMPLE;
                else           cnt_nx   = cnt - CW'(1);
            end
            SAMPLE: begin
                if (adc_valid) begin
                    if (gt) begin
                        lv_nx       = adc_data;
                        peak_pos_nx = pos;
                    end
                    if (pos != LAST) begin
                        pos_nx   = pos + POS_W'(1);
                        cnt_nx   = RELOAD;
                        state_nx = SETTLE;
                    end else begin
                        // Park on the peak; a load on this last sample makes pos itself the peak.
                        pos_nx   = gt ? pos : peak_pos;
                        state_nx = DONE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_sweep_peak_hold.sv
// Directed bench for sweep_peak_hold with a behavioural 6-MSB comparator in the loop.
module tb_sweep_peak_hold;
    localparam int DATA_W = 12;
    localparam int POS_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              adc_valid = 1'b0;
    logic              gt;
    logic [DATA_W-1:0] lv;
    logic [POS_W-1:0]  pos, peak_pos;
    logic              busy, done;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] samp [16];

    always #5 clk = ~clk;

    // Upstream comparator: coarse compare on the 6 MSBs only.
    assign gt = (adc_data[11:6] > lv[11:6]);

    sweep_peak_hold #(
        .DATA_W(DATA_W), .POS_W(POS_W), .POS_MAX(15), .SETTLE_CYCLES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .adc_data(adc_data),
        .adc_valid(adc_valid), .gt(gt), .lv(lv), .pos(pos),
        .peak_pos(peak_pos), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one sweep. junk drives 0xFFF with valid during SETTLE; delay_pos holds
    // valid low for delay_n SAMPLE cycles there; start_pos pulses start mid-sweep.
    task automatic run_sweep(input string tag, input bit junk, input int delay_pos,
                             input int delay_n, input int start_pos, input int abort_pos,
                             input bit start_in_done, output int cycles, output bit got_done);
        int prev_pos, at_pos, mono_err;
        bit aborted;
        cycles = 0; got_done = 0; aborted = 0;
        prev_pos = -1; at_pos = 0; mono_err = 0;
        @(negedge clk);
        start = 1'b1; adc_valid = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 0) begin
                check({tag, "_busy_after_start"}, busy, 1);
                check({tag, "_pos_after_start"}, pos, 0);
            end
            if (done) begin
                got_done = 1;
                if (start_in_done) start = 1'b1;
                break;
            end
            if (abort_pos >= 0 && int'(pos) == abort_pos) begin
                rst_n = 1'b0;
                aborted = 1;
                break;
            end
            cycles++;
            if (int'(pos) != prev_pos) begin
                if (int'(pos) < prev_pos) mono_err++;
                prev_pos = int'(pos);
                at_pos = 1;
            end else begin
                at_pos++;
            end
            if (int'(pos) == start_pos && at_pos == 2) start = 1'b1;
            if (junk && at_pos <= 3) begin
                adc_valid = 1'b1;
                adc_data  = 12'hFFF;
            end else if (int'(pos) == delay_pos && at_pos <= 3 + delay_n) begin
                adc_valid = 1'b0;
                adc_data  = 12'hFFF;
            end else begin
                adc_valid = 1'b1;
                adc_data  = samp[pos[3:0]];
            end
        end
        if (!got_done && !aborted) check({tag, "_timeout"}, 0, 1);
        check({tag, "_pos_monotonic"}, mono_err, 0);
        if (got_done) begin
            @(negedge clk);
            start = 1'b0;
            adc_valid = 1'b0;
            check({tag, "_done_one_cycle"}, done, 0);
            check({tag, "_busy_after_done"}, busy, 0);
        end
    endtask

    task automatic expect_result(input string tag, input int cycles, input bit got_done,
                                 input int exp_cycles, input logic [11:0] exp_lv,
                                 input logic [7:0] exp_peak);
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_cycles"}, cycles, exp_cycles);
        check({tag, "_lv"}, lv, exp_lv);
        check({tag, "_peak_pos"}, peak_pos, exp_peak);
        check({tag, "_pos_parked"}, pos, exp_peak);
    endtask

    initial begin
        int  cyc;
        bit  dn;
        int  done_in_reset;

        #1;
        check("rst_lv", lv, 0);
        check("rst_pos", pos, 0);
        check("rst_peak", peak_pos, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single peak, with start held high during the DONE cycle
        for (int i = 0; i < 16; i++) samp[i] = 12'h100;
        samp[9] = 12'hFC0;
        run_sweep("single", 0, -1, 0, -1, -1, 1, cyc, dn);
        expect_result("single", cyc, dn, 64, 12'hFC0, 8'd9);

        // Rising ramp, loads on the last sample
        for (int i = 0; i < 16; i++) samp[i] = 12'(i * 12'h100);
        run_sweep("ramp", 0, -1, 0, -1, -1, 0, cyc, dn);
        expect_result("ramp", cyc, dn, 64, 12'hF00, 8'd15);

        // Coarse tie: first position wins
        for (int i = 0; i < 16; i++) samp[i] = 12'h000;
        samp[4]  = 12'h840;
        samp[11] = 12'h87F;
        run_sweep("tie", 0, -1, 0, -1, -1, 0, cyc, dn);
        expect_result("tie", cyc, dn, 64, 12'h840, 8'd4);

        // Small values never clear the coarse compare
        for (int i = 0; i < 16; i++) samp[i] = 12'h03F;
        run_sweep("small", 0, -1, 0, -1, -1, 0, cyc, dn);
        expect_result("small", cyc, dn, 64, 12'h000, 8'd0);

        // Handshake: junk during SETTLE, 5-cycle valid delay at pos 3, start at pos 5
        for (int i = 0; i < 16; i++) samp[i] = 12'h100;
        samp[9] = 12'hFC0;
        run_sweep("hshake", 1, 3, 5, 5, -1, 0, cyc, dn);
        expect_result("hshake", cyc, dn, 69, 12'hFC0, 8'd9);

        // Reset mid-sweep at pos 7
        for (int i = 0; i < 16; i++) samp[i] = 12'(i * 12'h100);
        run_sweep("abort", 0, -1, 0, -1, 7, 0, cyc, dn);
        check("abort_no_done", dn, 0);
        check("abort_cycles", cyc, 28);
        #1;
        check("abort_lv", lv, 0);
        check("abort_pos", pos, 0);
        check("abort_peak", peak_pos, 0);
        check("abort_busy", busy, 0);
        done_in_reset = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_in_reset++;
        end
        check("abort_done_in_reset", done_in_reset, 0);
        rst_n = 1'b1;
        adc_valid = 1'b0;
        run_sweep("after_abort", 0, -1, 0, -1, -1, 0, cyc, dn);
        expect_result("after_abort", cyc, dn, 64, 12'hF00, 8'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
